// File: rtl/alu_multicycle_if.sv
// Handshake bus for alu_multicycle: request side (Operation/A/B) and registered result side.
// The master modport belongs to the pipeline driving the ALU; the slave modport belongs to the ALU.
interface alu_multicycle_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  busy;

    modport master (
        output in_valid, Operation, A, B, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, Operation, A, B, out_ready,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops, one-bit-per-cycle shifts, and an
// optional shift-add multiplier compiled in when ALU_MUL_EN is defined.
module alu_multicycle #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_multicycle_if.slave   bus
);
    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0011;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    // Encodings of SLL/SRL/SRA match Operation[1:0] so the opcode can be cast directly.
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA, K_MUL} kind_t;

    state_t                state;
    kind_t                 kind;
    logic [DATA_WIDTH-1:0] work;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] step_val;
    logic [DATA_WIDTH-1:0] alu_val;
    logic [SHW:0]          cnt;
    logic [SHW-1:0]        shamt;
    logic                  zero;
    logic                  out_valid;
    logic                  busy;
    logic                  accept;
`ifdef ALU_MUL_EN
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
`endif

    assign shamt        = bus.B[SHW-1:0];
    assign bus.in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid;
    assign bus.ALUResult = result;
    assign bus.Zero      = zero;
    assign bus.busy      = busy;

    always_comb begin
        alu_val = '0;
        case (bus.Operation)
            OP_AND: alu_val = bus.A & bus.B;
            OP_OR:  alu_val = bus.A | bus.B;
            OP_ADD: alu_val = bus.A + bus.B;
            OP_SUB: alu_val = bus.A - bus.B;
            OP_SLT: alu_val[0] = $signed(bus.A) < $signed(bus.B);
            OP_XOR: alu_val = bus.A ^ bus.B;
            default: alu_val = '0;
        endcase
    end

    // work doubles as the running product for the multiplier.
    always_comb begin
        step_val = work;
        case (kind)
            K_SLL: step_val = work << 1;
            K_SRL: step_val = work >> 1;
            K_SRA: step_val = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
`ifdef ALU_MUL_EN
            K_MUL: step_val = work + (mplier[0] ? mcand : '0);
`else
            K_MUL: step_val = work;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kind      <= K_SLL;
            work      <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else begin
            case (state)
                BUSY: begin
                    work <= step_val;
                    cnt  <= cnt - 1'b1;
`ifdef ALU_MUL_EN
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`endif
                    if (cnt == (SHW+1)'(1)) begin
                        result    <= step_val;
                        zero      <= (step_val == '0);
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        case (bus.Operation)
                            OP_SLL, OP_SRL, OP_SRA: begin
                                kind <= kind_t'(bus.Operation[1:0]);
                                work <= bus.A;
                                cnt  <= {1'b0, shamt};
                                if (shamt == '0) begin
                                    result    <= bus.A;
                                    zero      <= (bus.A == '0);
                                    state     <= HOLD;
                                    out_valid <= 1'b1;
                                    busy      <= 1'b0;
                                end else begin
                                    state     <= BUSY;
                                    out_valid <= 1'b0;
                                    busy      <= 1'b1;
                                end
                            end
`ifdef ALU_MUL_EN
                            OP_MUL: begin
                                kind      <= K_MUL;
                                work      <= '0;
                                mcand     <= bus.A;
                                mplier    <= bus.B;
                                cnt       <= (SHW+1)'(DATA_WIDTH);
                                state     <= BUSY;
                                out_valid <= 1'b0;
                                busy      <= 1'b1;
                            end
`endif
                            default: begin
                                result    <= alu_val;
                                zero      <= (alu_val == '0);
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end
                        endcase
                    end else if ((state == HOLD) && bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table with expected result/latency, plus
// hand-written back-to-back, backpressure and reset-abort sequences.
module tb_alu_multicycle;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_UND = 4'b1111;

`ifdef ALU_MUL_EN
    localparam logic [31:0] MUL1_RES = 32'hFFFF_FFFD;
    localparam logic [31:0] MUL2_RES = 32'h007F_B6F6;
    localparam int unsigned MUL_LAT  = 33;
`else
    localparam logic [31:0] MUL1_RES = 32'h0000_0000;
    localparam logic [31:0] MUL2_RES = 32'h0000_0000;
    localparam int unsigned MUL_LAT  = 1;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int unsigned lat;
    } vec_t;

    localparam int unsigned NVEC = 18;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    alu_multicycle_if #(.DATA_WIDTH(32)) bus ();

    alu_multicycle #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE with out_ready high; latency counts the accepting edge as 1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int unsigned lat);
        @(negedge clk);
        bus.Operation = op;
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = bus.ALUResult;
        z   = bus.Zero;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int unsigned lat;
        int unsigned stale;

        vecs[0]  = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1};
        vecs[1]  = '{OP_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1};
        vecs[2]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[3]  = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1};
        vecs[4]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
        vecs[5]  = '{OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[6]  = '{OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1};
        vecs[7]  = '{OP_XOR, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1};
        vecs[8]  = '{OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};
        vecs[9]  = '{OP_SLL, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060, 6};
        vecs[10] = '{OP_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5};
        vecs[11] = '{OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5};
        vecs[12] = '{OP_SRA, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000, 5};
        vecs[13] = '{OP_SRA, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1};
        vecs[14] = '{OP_SRL, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 2};
        vecs[15] = '{OP_UND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[16] = '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, MUL1_RES, MUL_LAT};
        vecs[17] = '{OP_MUL, 32'd12345,     32'd678,       MUL2_RES, MUL_LAT};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Operation = 4'b0000;
        bus.A         = '0;
        bus.B         = '0;
        reset         = 1'b1;
        #12;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result",    bus.ALUResult,          32'd0);
        chk("rst_zero",      {31'd0, bus.Zero},      32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].res == 32'd0});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Back-to-back single-cycle ops with out_ready held high.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.Operation = OP_ADD; bus.A = 32'd5; bus.B = 32'd7; bus.in_valid = 1'b1;
        chk("b2b_ready0", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_add_res",   bus.ALUResult, 32'd12);
        chk("b2b_add_zero",  {31'd0, bus.Zero}, 32'd0);
        chk("b2b_ready1",    {31'd0, bus.in_ready}, 32'd1);
        bus.Operation = OP_SUB; bus.A = 32'd5; bus.B = 32'd5;
        @(negedge clk);
        chk("b2b_sub_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_sub_res",   bus.ALUResult, 32'd0);
        chk("b2b_sub_zero",  {31'd0, bus.Zero}, 32'd1);
        chk("b2b_ready2",    {31'd0, bus.in_ready}, 32'd1);
        bus.Operation = OP_SLT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
        @(negedge clk);
        chk("b2b_slt_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_slt_res",   bus.ALUResult, 32'd1);
        chk("b2b_slt_zero",  {31'd0, bus.Zero}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: result held while out_ready low; queued op accepted when it rises.
        bus.out_ready = 1'b0;
        bus.Operation = OP_XOR; bus.A = 32'hFF00_FF00; bus.B = 32'h0F0F_0F0F; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.Operation = OP_ADD; bus.A = 32'h10; bus.B = 32'h20;
            chk($sformatf("bp_valid%0d", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp_res%0d", i),   bus.ALUResult, 32'hF00F_F00F);
            chk($sformatf("bp_ready%0d", i), {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        chk("bp_res_held", bus.ALUResult, 32'hF00F_F00F);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_second_res",   bus.ALUResult, 32'h30);
        @(negedge clk);
        chk("bp_idle_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a long SLL.
        bus.Operation = OP_SLL; bus.A = 32'd1; bus.B = 32'd20; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sll_busy",     {31'd0, bus.busy},     32'd1);
        chk("sll_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("sll_no_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_result",    bus.ALUResult,          32'd0);
        chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("abort_busy",      {31'd0, bus.busy},      32'd0);
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("abort_no_stale", stale, 32'd0);
        run_op(OP_ADD, 32'd1, 32'd1, res, z, lat);
        chk("post_reset_res", res, 32'd2);
        chk("post_reset_lat", lat, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU controller and operand pair from the register-read stage, and returns a registered result with a zero flag. Logic ops, add/sub and SLT complete in one cycle; shifts run iteratively one bit per cycle; an optional shift-add multiplier is compiled in by macro. Valid/ready handshakes on both sides let the pipeline stall while a multi-cycle op is in flight.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, 8..64; shift amount is B[log2(DATA_WIDTH)-1:0]
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  Operation/A/B valid this cycle
- in_ready  output  1  block accepts an operation this cycle
- Operation  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 XOR, 1000 SLL, 1001 SRL, 1010 SRA, 0011 MUL (macro only)
- A  input  DATA_WIDTH  operand 1
- B  input  DATA_WIDTH  operand 2 / shift amount
- out_valid  output  1  ALUResult/Zero valid
- out_ready  input  1  consumer takes result this cycle
- ALUResult  output  DATA_WIDTH  registered result
- Zero  output  1  registered, 1 iff ALUResult == 0
- busy  output  1  1 while in BUSY state

## Operation
- States: IDLE, BUSY, HOLD. Reset: state IDLE, in_ready 1, out_valid 0, ALUResult 0, Zero 0, busy 0, working registers and counter 0.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready; Operation/A/B sampled only on accept.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, XOR, any undefined code): result computed and registered on accepting edge; state -> HOLD. Undefined codes (incl. 0011 without macro) give ALUResult 0, Zero 1.
- ADD/SUB wrap modulo 2^DATA_WIDTH, no overflow flag. SLT: 1 if $signed(A) < $signed(B), else 0.
- Shifts: on accept, work=A, cnt=shamt. shamt==0: ALUResult=A, -> HOLD. Otherwise -> BUSY; each BUSY edge shifts work by one (SLL zero-fill left, SRL zero-fill right, SRA replicate MSB) and decrements cnt; edge where cnt goes 1->0 writes work-shifted to ALUResult and -> HOLD.
- HOLD: out_valid 1, ALUResult/Zero stable. out_ready & !in_valid -> IDLE, out_valid 0. out_ready & in_valid -> accepts new op same edge (back-to-back), next state per new op. !out_ready -> stay HOLD.
- BUSY: in_ready 0, out_valid 0; in_valid and out_ready ignored.
- Zero always updated together with ALUResult.

## Timing
- Latency L = rising edges from accept (accepting edge = 1) to out_valid high: 1 for single-cycle ops and shamt 0; shamt+1 for shamt>=1; DATA_WIDTH+1 for MUL.
- Throughput: one single-cycle op per cycle when out_ready held high.
- Asynchronous reset mid-BUSY or mid-HOLD aborts immediately: all outputs to reset values, pending result discarded; first accept possible on first edge after reset deasserts.
- in_ready is combinational from state and out_ready; no combinational path from in_valid to any output.

## Configuration
- ALU_MUL_EN defined: Operation 0011 = unsigned shift-add multiply, low DATA_WIDTH bits of A*B; on accept product=0, mcand=A, mplier=B, cnt=DATA_WIDTH, -> BUSY; each edge adds mcand if mplier[0], mcand<<=1, mplier>>=1; on cnt 1->0 writes ALUResult, -> HOLD.
- ALU_MUL_EN undefined: no multiplier registers; 0011 treated as undefined (result 0, single cycle).

## Test plan
- Reset mid-SLL (A=1, B=20, reset after 5 BUSY cycles) -> out_valid 0, ALUResult 0, in_ready 1 immediately; no stale result after release.
- Back-to-back ADD 5+7, SUB 5-5, SLT -1<1 with out_ready=1 -> results 12/Zero 0, 0/Zero 1, 1/Zero 0 on three consecutive cycles, in_ready never low.
- SRA A=0x8000_0000, B=4 -> out_valid on 5th edge after accept, ALUResult 0xF800_0000; SRL same operands -> 0x0800_0000; shamt 0 -> A in 1 cycle.
- Backpressure: XOR 0xFF00FF00^0x0F0F0F0F with out_ready=0 for 3 cycles -> 0xF00FF00F held stable, in_ready 0, second op accepted on edge out_ready rises.
- ALU_MUL_EN: 0011 A=0xFFFF_FFFF, B=3 -> 0xFFFF_FFFD after 33 edges; without macro -> 0, Zero 1, latency 1.
- Undefined code 1111 A=B=0xFFFF_FFFF -> ALUResult 0, Zero 1, latency 1.
